// File: rtl/qam_tx_sequencer_if.sv
// Control and status bundle between the QAM burst host/FIFO side
// and the qam_tx_sequencer burst controller.
interface qam_tx_sequencer_if #(
    parameter int LEN_WIDTH   = 16,
    parameter int LEVEL_WIDTH = 7
);
    logic                   start;
    logic                   stop;
    logic [LEN_WIDTH-1:0]   burst_len;
    logic [LEVEL_WIDTH-1:0] fifo_level;
    logic                   fifo_empty;
    logic                   carrier_zero;
    logic                   rd_en;
    logic                   busy;
    logic                   done;
    logic [LEN_WIDTH-1:0]   sample_cnt;
    logic                   err_underflow;
    logic                   err_timeout;
    logic                   err_cfg;

    modport master (
        output start, stop, burst_len, fifo_level,
        output fifo_empty, carrier_zero,
        input  rd_en, busy, done, sample_cnt,
        input  err_underflow, err_timeout, err_cfg
    );

    modport slave (
        input  start, stop, burst_len, fifo_level,
        input  fifo_empty, carrier_zero,
        output rd_en, busy, done, sample_cnt,
        output err_underflow, err_timeout, err_cfg
    );
endinterface

// File: rtl/qam_tx_sequencer.sv
// Sequenced FIFO read burst for the QAM-16 back end: prefill, align
// to carrier zero phase, read N samples, then flush the DSP pipeline.
module qam_tx_sequencer #(
    parameter int LEN_WIDTH    = 16,
    parameter int LEVEL_WIDTH  = 7,
    parameter int PREFILL      = 8,
    parameter int ZERO_TIMEOUT = 64,
    parameter int PIPE_LAT     = 4
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    qam_tx_sequencer_if.slave bus
);
    localparam int CMAX = (ZERO_TIMEOUT > PIPE_LAT) ? ZERO_TIMEOUT : PIPE_LAT;
    localparam int TW   = $clog2(CMAX) + 1;

    localparam logic [TW-1:0]          TO_LAST = TW'(ZERO_TIMEOUT - 1);
    localparam logic [TW-1:0]          DR_LAST = TW'(PIPE_LAT - 1);
    localparam logic [LEVEL_WIDTH-1:0] PF_LVL  = LEVEL_WIDTH'(PREFILL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_ARM,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] smp_q, smp_d;
    logic                 busy_q;
    logic                 done_q, done_d;
    logic                 uf_q, uf_d;
    logic                 to_q, to_d;
    logic                 cfg_q, cfg_d;
    logic                 rd_en;
    logic                 last_rd;

    // Combinational so a read is never issued on an empty FIFO.
    assign rd_en   = (state_q == S_RUN) && !bus.fifo_empty;
    assign last_rd = rd_en && (smp_q == len_q - LEN_WIDTH'(1));

    assign bus.rd_en         = rd_en;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.sample_cnt    = smp_q;
    assign bus.err_underflow = uf_q;
    assign bus.err_timeout   = to_q;
    assign bus.err_cfg       = cfg_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        smp_d   = smp_q;
        done_d  = 1'b0;
        uf_d    = uf_q;
        to_d    = to_q;
        cfg_d   = cfg_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    smp_d = '0;
                    uf_d  = 1'b0;
                    to_d  = 1'b0;
                    cfg_d = 1'b0;
                    if (bus.burst_len == '0) begin
                        cfg_d = 1'b1;
                    end else begin
                        len_d   = bus.burst_len;
                        state_d = S_PREFILL;
                    end
                end
            end
            S_PREFILL: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (bus.fifo_level >= PF_LVL) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                end
            end
            S_ARM: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (bus.carrier_zero) begin
                    state_d = S_RUN;
                end else if (cnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_RUN: begin
                if (rd_en && (smp_q < len_q)) begin
                    smp_d = smp_q + LEN_WIDTH'(1);
                end
                // Truncate on underflow; the burst is never resumed.
                if (bus.fifo_empty && (smp_q < len_q)) begin
                    uf_d    = 1'b1;
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
                if (last_rd || bus.stop) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DR_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            smp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            uf_q    <= 1'b0;
            to_q    <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            smp_q   <= smp_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
            uf_q    <= uf_d;
            to_q    <= to_d;
            cfg_q   <= cfg_d;
        end
    end
endmodule

// File: tb/tb_qam_tx_sequencer.sv
// Scoreboard bench for qam_tx_sequencer: stimulus pushes the expected
// burst outcome, a monitor checks it on each done pulse.
module tb_qam_tx_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int done_cyc;
        int first_rd;
        int nrd;
        int cnt;
        int uf;
        int to;
    } exp_t;

    exp_t sb[$];
    int   mon_nrd = 0;
    int   mon_first = -1;

    qam_tx_sequencer_if #(.LEN_WIDTH(16), .LEVEL_WIDTH(7)) bus ();

    qam_tx_sequencer dut (
        .axi_clk (clk),
        .axi_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_nrd   = 0;
            mon_first = -1;
        end else begin
            if (bus.rd_en) begin
                chk("rd_en_while_empty", int'(bus.fifo_empty), 0);
                if (mon_first < 0) mon_first = cyc;
                mon_nrd++;
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("first_rd", mon_first, e.first_rd);
                    chk("rd_count", mon_nrd, e.nrd);
                    chk("sample_cnt", int'(bus.sample_cnt), e.cnt);
                    chk("err_underflow", int'(bus.err_underflow), e.uf);
                    chk("err_timeout", int'(bus.err_timeout), e.to);
                    chk("err_cfg", int'(bus.err_cfg), 0);
                    chk("busy_at_done", int'(bus.busy), 0);
                end
                mon_nrd   = 0;
                mon_first = -1;
            end
        end
    end

    task automatic burst(input int len, input int lvl, input int lvl_k,
                         input int cz_k, input int cz_per, input int stop_k,
                         input int ef, input int et, input int ncyc,
                         input int d_rel, input int f_rel, input int nrd,
                         input int cnt, input int uf, input int to);
        int   t0;
        exp_t e;
        t0 = cyc;
        e.done_cyc = t0 + d_rel;
        e.first_rd = (f_rel < 0) ? -1 : t0 + f_rel;
        e.nrd      = nrd;
        e.cnt      = cnt;
        e.uf       = uf;
        e.to       = to;
        sb.push_back(e);
        for (int k = 0; k < ncyc; k++) begin
            bus.start        = (k == 0);
            bus.burst_len    = (k == 0) ? 16'(len) : 16'hFFFF;
            bus.fifo_level   = (k >= lvl_k) ? 7'(lvl) : 7'd0;
            bus.carrier_zero = (cz_per > 0) ? ((k % cz_per) == 0)
                                            : (k == cz_k);
            bus.stop         = (k == stop_k);
            bus.fifo_empty   = (k >= ef) && (k < et);
            tick();
        end
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.carrier_zero = 1'b0;
        bus.fifo_empty   = 1'b0;
    endtask

    task automatic drain_sb();
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            chk("done_timeout_pending", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.burst_len    = '0;
        bus.fifo_level   = '0;
        bus.fifo_empty   = 1'b0;
        bus.carrier_zero = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_rd_en", int'(bus.rd_en), 0);
        chk("rst_sample_cnt", int'(bus.sample_cnt), 0);
        chk("rst_errs", int'({bus.err_underflow, bus.err_timeout,
                              bus.err_cfg}), 0);

        // nominal, then a single-sample burst with zero phase on first ARM cycle
        burst(5, 20, 0, 4, 0, -1, -1, -1, 16, 14, 5, 5, 5, 0, 0);
        burst(1, 20, 0, 2, 0, -1, -1, -1, 10, 8, 3, 1, 1, 0, 0);
        // prefill gating with periodic zero phase
        burst(3, 8, 10, -1, 4, -1, -1, -1, 25, 20, 13, 3, 3, 0, 0);
        // underflow after 6 reads, then a clean burst clears the flag
        burst(10, 20, 0, 4, 0, -1, 11, 17, 20, 16, 5, 6, 6, 1, 0);
        burst(2, 20, 0, 4, 0, -1, -1, -1, 13, 11, 5, 2, 2, 0, 0);
        // carrier zero never arrives
        burst(4, 20, 0, -1, 0, -1, -1, -1, 70, 66, -1, 0, 0, 0, 1);
        // stop in RUN after 3 reads (stop-cycle read counts), PREFILL, ARM
        burst(10, 20, 0, 4, 0, 8, -1, -1, 16, 13, 5, 4, 4, 0, 0);
        burst(4, 0, 0, -1, 0, 3, -1, -1, 6, 4, -1, 0, 0, 0, 0);
        burst(4, 20, 0, -1, 0, 3, -1, -1, 6, 4, -1, 0, 0, 0, 0);
        drain_sb();

        bus.start     = 1'b1;
        bus.stop      = 1'b1;
        bus.burst_len = 16'd5;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("collide_busy", int'(bus.busy), 0);
        repeat (3) tick();
        chk("collide_busy_later", int'(bus.busy), 0);

        bus.start     = 1'b1;
        bus.burst_len = 16'd0;
        tick();
        bus.start = 1'b0;
        chk("cfg_err", int'(bus.err_cfg), 1);
        chk("cfg_busy", int'(bus.busy), 0);
        tick();
        chk("cfg_busy_later", int'(bus.busy), 0);
        chk("cfg_err_sticky", int'(bus.err_cfg), 1);

        burst(3, 20, 0, 4, 0, -1, -1, -1, 14, 12, 5, 3, 3, 0, 0);
        drain_sb();

        // reset mid-RUN: no done, outputs back to reset values
        for (int k = 0; k < 8; k++) begin
            bus.start        = (k == 0);
            bus.burst_len    = 16'd10;
            bus.fifo_level   = 7'd20;
            bus.carrier_zero = (k == 4);
            rst              = (k == 7);
            tick();
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_done", int'(bus.done), 0);
        chk("mrst_rd_en", int'(bus.rd_en), 0);
        chk("mrst_sample_cnt", int'(bus.sample_cnt), 0);
        chk("mrst_errs", int'({bus.err_underflow, bus.err_timeout,
                               bus.err_cfg}), 0);
        repeat (10) tick();
        burst(2, 20, 0, 4, 0, -1, -1, -1, 13, 11, 5, 2, 2, 0, 0);
        drain_sb();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
